logic_exec_stage: RTL and testbench
===================================

Name: logic_exec_stage

Overview:
- Execute-stage logic unit sitting directly downstream of the decode/operand-fetch stage and upstream of writeback.
- Registers one decoded logic/shift operation per cycle and computes the bitwise OR/AND/XOR/NOR results using the team's existing 32-bit gate-level units.
- Presents the registered result to writeback over a valid/ready handshake.
- Includes a one-entry skid buffer, so full throughput is held under writeback backpressure with a registered in_ready.

Parameters:
- WIDTH, 32, datapath width in bits.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  stage can accept; registered.
- in_op  input  3  operation code (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B; shift amount in in_b[4:0].
- in_rd  input  RD_W  destination register.
- out_valid  output  1  result available to writeback.
- out_ready  input  1  writeback accepts.
- out_result  output  WIDTH  computed result.
- out_rd  output  RD_W  destination register, passed through.
- out_zero  output  1  out_result == 0.
- out_illegal  output  1  in_op was a reserved code.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR.
  - 4 SLL, 5 SRL, 6 SRA; shift amount is in_b[4:0], SRA sign-fills from in_a[31].
  - 7 reserved: result 0, illegal=1.
- Result is computed combinationally at the input and captured into the output register. Latency is 1 cycle from the accept edge to out_valid.
- Accept on in_valid & in_ready. Transfer on out_valid & out_ready.
- Reset (async): out_valid=0, skid_valid=0, in_ready=1, out_result=0, out_rd=0, out_zero=1, out_illegal=0.
- States, encoded by {out_valid, skid_valid}:
  - EMPTY {0,0}
  - BUSY {1,0}
  - FULL {1,1}
  - {0,1} is unreachable.
- EMPTY: an accept loads the output register and goes to BUSY.
- BUSY:
  - Accept and transfer together: output register reloads; stay BUSY (full throughput).
  - Accept without transfer: computed beat goes to the skid register; go to FULL; in_ready drops next cycle.
  - Transfer without accept: go to EMPTY.
- FULL:
  - in_ready=0, so no accept is possible.
  - On transfer, the skid contents move to the output register; go to BUSY; in_ready=1 next cycle.
- in_ready is the registered value !skid_valid_next. It never depends combinationally on out_ready.
- Output fields are stable while out_valid=1 and out_ready=0.
- Skid captures the computed result, rd, zero and illegal. It does not capture raw operands, so no recompute is needed.
- flush=1:
  - Next cycle: out_valid=0, skid_valid=0, in_ready=1.
  - Any beat offered in the flush cycle is discarded, even if in_ready was 1.
  - flush takes priority over a simultaneous transfer; writeback must ignore that transfer.
- out_zero and out_illegal are registered alongside out_result. No combinational path from in_* to out_*.
- Shift amounts ≥ WIDTH are impossible; only 5 bits are used.

Decomposition:
- Shared package fusion_exec_pkg:
  - Opcode constants OP_AND..OP_SRA, OP_RSVD.
  - Result bundle struct {result, rd, zero, illegal}.
  - WIDTH default.
- One sub-module, logic_exec_alu: purely combinational op select. It instantiates the existing 32-bit and/or/xor units, plus NOR as the inversion of the OR output and a barrel shifter.
- logic_exec_stage holds only the handshake FSM and the output/skid registers.

Test Plan:
- Reset mid-stream: assert rst asynchronously while FULL -> out_valid=0, in_ready=1 immediately, out_zero=1.
- Basic ops with out_ready=1: a=0xF0F0_0000, b=0x0F0F_00FF, OR -> 0xFFFF_00FF; AND -> 0x0000_0000 with out_zero=1; NOR -> 0x0000_FF00. Each appears 1 cycle after accept.
- Shifts: a=0x8000_0001, b=4:
  - SLL -> 0x0000_0010.
  - SRL -> 0x0800_0000.
  - SRA -> 0xF800_0000.
  - Op 7 -> result 0, out_illegal=1.
- Backpressure: stream 4 ops at full rate, hold out_ready=0 for 3 cycles -> second beat lands in skid, in_ready=0 from the following cycle, no beat lost or duplicated, in-order drain once out_ready=1.
- Flush while FULL with in_valid=1 -> both entries dropped, in_ready=1 and out_valid=0 next cycle, no output ever shows the flushed rd values.
- Random throughput check: random in_valid/out_ready for 10k cycles against a reference model -> identical ordered result/rd stream and 100% throughput whenever out_ready is continuously high.

Source files
------------

// File: rtl/fusion_exec_pkg.sv
// ============================================================================
// Module      : fusion_exec_pkg
// Description : Shared opcodes, result bundle and stage states for the
//               execute-stage logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fusion_exec_pkg;

    localparam int EXEC_WIDTH = 32;
    localparam int EXEC_RD_W  = 5;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_SLL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef struct packed {
        logic [EXEC_WIDTH-1:0] result;
        logic [EXEC_RD_W-1:0]  rd;
        logic                  zero;
        logic                  illegal;
    } exec_res_t;

    // Encoding is {out_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

    localparam exec_res_t RES_RESET = '{result: '0, rd: '0, zero: 1'b1, illegal: 1'b0};

endpackage

`default_nettype wire

// File: rtl/logic_exec_alu.sv
// ============================================================================
// Module      : logic_exec_alu
// Description : Combinational logic/shift operation select feeding the stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_exec_alu
    import fusion_exec_pkg::*;
(
    input  logic [2:0]            op_i,
    input  logic [EXEC_WIDTH-1:0] a_i,
    input  logic [EXEC_WIDTH-1:0] b_i,
    input  logic [EXEC_RD_W-1:0]  rd_i,
    output exec_res_t             res_o
);

    localparam int SHAMT_W = $clog2(EXEC_WIDTH);

    logic [EXEC_WIDTH-1:0] w_and;
    logic [EXEC_WIDTH-1:0] w_or;
    logic [EXEC_WIDTH-1:0] w_xor;
    logic [EXEC_WIDTH-1:0] w_nor;
    logic [EXEC_WIDTH-1:0] w_a_rev;
    logic [EXEC_WIDTH-1:0] w_sh_in;
    logic [EXEC_WIDTH-1:0] w_sll;
    logic [EXEC_WIDTH-1:0] w_stage [0:SHAMT_W];
    logic                  w_fill;
    logic [EXEC_WIDTH-1:0] w_result;
    logic                  w_illegal;

    // 32-bit gate-level and/or/xor units; NOR is the inverted OR output.
    genvar i;
    generate
        for (i = 0; i < EXEC_WIDTH; i++) begin : g_bit
            and u_and (w_and[i], a_i[i], b_i[i]);
            or  u_or  (w_or[i],  a_i[i], b_i[i]);
            xor u_xor (w_xor[i], a_i[i], b_i[i]);
            not u_nor (w_nor[i], w_or[i]);
            assign w_a_rev[i] = a_i[EXEC_WIDTH-1-i];
            assign w_sll[i]   = w_stage[SHAMT_W][EXEC_WIDTH-1-i];
        end
    endgenerate

    // A single right-shifting barrel; left shifts run through it bit-reversed.
    assign w_sh_in    = (op_i == OP_SLL) ? w_a_rev : a_i;
    assign w_fill     = (op_i == OP_SRA) & a_i[EXEC_WIDTH-1];
    assign w_stage[0] = w_sh_in;

    genvar s;
    generate
        for (s = 0; s < SHAMT_W; s++) begin : g_stage
            assign w_stage[s+1] = b_i[s]
                ? {{(2**s){w_fill}}, w_stage[s][EXEC_WIDTH-1:2**s]}
                : w_stage[s];
        end
    endgenerate

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (op_i)
            OP_AND:         w_result = w_and;
            OP_OR:          w_result = w_or;
            OP_XOR:         w_result = w_xor;
            OP_NOR:         w_result = w_nor;
            OP_SLL:         w_result = w_sll;
            OP_SRL, OP_SRA: w_result = w_stage[SHAMT_W];
            default:        w_illegal = 1'b1;
        endcase
    end

    assign res_o = '{result: w_result, rd: rd_i, zero: ~|w_result, illegal: w_illegal};

endmodule

`default_nettype wire

// File: rtl/logic_exec_stage.sv
// ============================================================================
// Module      : logic_exec_stage
// Description : Execute-stage logic unit with registered output and one-entry
//               skid buffer on a valid/ready handshake to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_exec_stage
    import fusion_exec_pkg::*;
#(
    parameter int WIDTH = EXEC_WIDTH,
    parameter int RD_W  = EXEC_RD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_zero,
    output logic             out_illegal
);

    exec_res_t    w_alu_res;
    exec_res_t    out_q;
    exec_res_t    skid_q;
    stage_state_e state_q;
    logic         in_ready_q;
    logic         w_accept;
    logic         w_xfer;

    logic_exec_alu u_alu (
        .op_i  (in_op),
        .a_i   (in_a),
        .b_i   (in_b),
        .rd_i  (in_rd),
        .res_o (w_alu_res)
    );

    assign w_accept = in_valid & in_ready_q;
    assign w_xfer   = out_valid & out_ready;

    // in_ready_q always tracks the inverse of the next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= RES_RESET;
            skid_q     <= RES_RESET;
        end else if (flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        out_q   <= w_alu_res;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_xfer) begin
                        out_q <= w_alu_res;
                    end else if (w_accept) begin
                        skid_q     <= w_alu_res;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (w_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_xfer) begin
                        out_q      <= skid_q;
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = state_q[1];
    assign out_result  = out_q.result;
    assign out_rd      = out_q.rd;
    assign out_zero    = out_q.zero;
    assign out_illegal = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_logic_exec_stage.sv
// ============================================================================
// Module      : tb_logic_exec_stage
// Description : Directed and random self-checking bench for logic_exec_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_exec_stage;

    localparam int WIDTH = 32;
    localparam int RD_W  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [RD_W-1:0]  in_rd = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic [RD_W-1:0]  out_rd;
    logic             out_zero;
    logic             out_illegal;

    int n_assert = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             illegal;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    logic_exec_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return a << b[4:0];
            3'd5:    return a >> b[4:0];
            3'd6:    return WIDTH'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    // Scoreboard: inputs change 1 time unit after posedge, so values at the
    // negedge are exactly those the next posedge will see.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (sb_en) begin
            chk("sb_out_valid", out_valid, exp_q.size() > 0);
            chk("sb_in_ready", in_ready, exp_q.size() < 2);
            if (out_valid && exp_q.size() > 0) begin
                chk("sb_result", out_result, exp_q[0].result);
                chk("sb_rd", out_rd, exp_q[0].rd);
                chk("sb_zero", out_zero, exp_q[0].result == '0);
                chk("sb_illegal", out_illegal, exp_q[0].illegal);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid && in_ready)
                    exp_q.push_back('{result: model(in_op, in_a, in_b), rd: in_rd,
                                      illegal: (in_op == 3'd7)});
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [RD_W-1:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, accept on the next edge, check the registered result.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res,
                         input logic exp_zero, input logic exp_ill);
        drive(op, a, b, 5'(op) + 5'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, out_result, exp_res);
        chk({tag, "_zero"}, out_zero, exp_zero);
        chk({tag, "_illegal"}, out_illegal, exp_ill);
        chk({tag, "_rd"}, out_rd, 5'(op) + 5'd1);
    endtask

    initial begin
        bit acc;
        bit fl_prev;

        // Reset values
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", out_result, 32'h0);
        chk("rst_rd", out_rd, 5'd0);
        chk("rst_zero", out_zero, 1'b1);
        chk("rst_illegal", out_illegal, 1'b0);
        rst = 1'b0;
        sb_en = 1'b1;
        step();

        // Basic logic ops and shifts
        do_op("or",   3'd1, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0, 1'b0);
        do_op("and",  3'd0, 32'hF0F0_0000, 32'h0F0F_00FF, 32'h0000_0000, 1'b1, 1'b0);
        do_op("nor",  3'd3, 32'hF0F0_0000, 32'h0F0F_00FF, 32'h0000_FF00, 1'b0, 1'b0);
        do_op("xor",  3'd2, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0, 1'b0);
        do_op("sll",  3'd4, 32'h8000_0001, 32'd4,         32'h0000_0010, 1'b0, 1'b0);
        do_op("srl",  3'd5, 32'h8000_0001, 32'd4,         32'h0800_0000, 1'b0, 1'b0);
        do_op("sra",  3'd6, 32'h8000_0001, 32'd4,         32'hF800_0000, 1'b0, 1'b0);
        do_op("rsvd", 3'd7, 32'h8000_0001, 32'd4,         32'h0000_0000, 1'b1, 1'b1);
        do_op("sra31", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("sll31", 3'd4, 32'h0000_0003, 32'd31,        32'h8000_0000, 1'b0, 1'b0);
        step();
        chk("idle_valid", out_valid, 1'b0);

        // Backpressure: second beat lands in skid, then in-order drain
        out_ready = 1'b0;
        drive(3'd1, 32'h1, 32'h0, 5'd1);
        step();
        chk("bp1_rd", out_rd, 5'd1);
        chk("bp1_in_ready", in_ready, 1'b1);
        drive(3'd1, 32'h2, 32'h0, 5'd2);
        step();
        chk("bp2_in_ready", in_ready, 1'b0);
        chk("bp2_rd", out_rd, 5'd1);
        drive(3'd1, 32'h3, 32'h0, 5'd3);
        step();
        chk("bp3_in_ready", in_ready, 1'b0);
        chk("bp3_stable_rd", out_rd, 5'd1);
        chk("bp3_stable_res", out_result, 32'h1);
        out_ready = 1'b1;
        step();
        chk("bp4_rd", out_rd, 5'd2);
        chk("bp4_in_ready", in_ready, 1'b1);
        step();
        chk("bp5_rd", out_rd, 5'd3);
        drive(3'd1, 32'h4, 32'h0, 5'd4);
        step();
        in_valid = 1'b0;
        chk("bp6_rd", out_rd, 5'd4);
        step();
        chk("bp7_valid", out_valid, 1'b0);

        // Flush while full with a beat offered
        out_ready = 1'b0;
        drive(3'd1, 32'hA, 32'h0, 5'd10);
        step();
        drive(3'd1, 32'hB, 32'h0, 5'd11);
        step();
        chk("fl_full_in_ready", in_ready, 1'b0);
        drive(3'd1, 32'hC, 32'h0, 5'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        step();
        chk("fl_after_valid", out_valid, 1'b0);

        // Flush in an empty stage discards a beat even with in_ready high
        drive(3'd1, 32'hD, 32'h0, 5'd13);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_empty_valid", out_valid, 1'b0);

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(3'd2, 32'h5, 32'h3, 5'd20);
        step();
        drive(3'd2, 32'h6, 32'h3, 5'd21);
        step();
        in_valid = 1'b0;
        chk("ar_full_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_zero", out_zero, 1'b1);
        chk("ar_result", out_result, 32'h0);
        step();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Random traffic against the scoreboard
        fl_prev = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            fl_prev = flush;
            @(posedge clk);
            #1;
            if (acc || fl_prev || !in_valid) begin
                if ($urandom_range(0, 9) < 7)
                    drive(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
                else
                    in_valid = 1'b0;
            end
            flush = ($urandom_range(0, 199) == 0);
            if (((i / 300) % 2) == 1) out_ready = 1'b1;
            else                      out_ready = ($urandom_range(0, 3) != 0);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("final_drained", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
